param_line_buffer_ring: RTL and testbench

//  Ring of NUM_LINES single-line RAMs that stores incoming feature-map rows and presents KSIZE vertically

---
 rtl/lb_pkg.sv | 18 +
 rtl/lb_sdp_ram.sv | 39 +++
 rtl/param_line_buffer_ring.sv | 221 ++++++++++++++++++++++
 tb/tb_param_line_buffer_ring.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the line-buffer ring.
//   lb_state_e    : fill-level state reported on the `state` port
//   LB_DATA_WIDTH : default bits per column word
//   LB_DEPTH      : default columns per line
//   LB_KSIZE      : default window height (rows presented per read)
package lb_pkg;

  typedef enum logic [1:0] {
    LB_FILL  = 2'd0,  // fewer than KSIZE complete lines
    LB_READY = 2'd1,  // KSIZE..NUM_LINES-1 complete lines, reads allowed
    LB_FULL  = 2'd2   // every line RAM holds a complete line, writes stall
  } lb_state_e;

  localparam int LB_DATA_WIDTH = 64;
  localparam int LB_DEPTH      = 512;
  localparam int LB_KSIZE      = 5;

endpackage

// File: rtl/lb_sdp_ram.sv
// Simple dual-port line RAM, DEPTH x DATA_WIDTH.
// One write port and one read port on the same clock. The read data is
// registered once (1-cycle latency), so the array maps onto block RAM.
// There is no extra output register.
//   clk   : clock
//   we    : write enable
//   waddr : write column
//   wdata : write word
//   re    : read enable; rdata holds its value while re is low
//   raddr : read column
//   rdata : word read on the previous enabled cycle
module lb_sdp_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on the array or on rdata: contents are don't-care after reset,
  // and the ring's output stage masks rdata whenever no read is in flight.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/param_line_buffer_ring.sv
// Ring of NUM_LINES single-line RAMs that buffers feature-map rows from the
// input stream and presents KSIZE vertically adjacent rows per column read.
// One line is filled while up to KSIZE complete lines are read.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous flush of pointers, counts, read pipeline and
//                  overflow flag (RAM contents are kept)
//   wr_valid/wr_ready/wr_data/wr_last : row word stream, one column per beat
//   rd_en/rd_ready/rd_addr : column read request, accepted when rd_ready
//   rd_release   : pulse, oldest complete line has been consumed
//   rd_valid/rd_data : read result 2 cycles after acceptance; slot 0 (LSBs)
//                  is the oldest line and slot KSIZE-1 the newest
//   lines_avail  : number of complete, unreleased lines
//   state        : LB_FILL / LB_READY / LB_FULL
//   overflow_err : sticky, a line reached DEPTH words without wr_last
module param_line_buffer_ring
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int DEPTH      = LB_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int KSIZE      = LB_KSIZE,
  parameter int NUM_LINES  = KSIZE + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_last,
  input  logic                             rd_en,
  output logic                             rd_ready,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             rd_release,
  output logic                             rd_valid,
  output logic [KSIZE*DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(NUM_LINES+1)-1:0]   lines_avail,
  output logic [1:0]                       state,
  output logic                             overflow_err
);

  localparam int LW = $clog2(NUM_LINES);
  localparam int CW = $clog2(NUM_LINES + 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [LW-1:0]               wline_q, wline_d;
  logic [LW-1:0]               rline_q, rline_d;
  logic [LW-1:0]               rline_s1_q, rline_s1_d;
  logic [ADDR_W-1:0]           wr_col_q, wr_col_d;
  logic [CW-1:0]               count_q, count_d;
  lb_state_e                   state_q, state_d;
  logic                        rd_s1_q, rd_s1_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [KSIZE*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                        ovf_q, ovf_d;

  logic                        wr_acc;
  logic                        rd_acc;
  logic                        col_end;
  logic                        line_close;
  logic                        rel;

  logic [NUM_LINES-1:0]        ram_we;
  logic [DATA_WIDTH-1:0]       ram_rdata [NUM_LINES];
  logic [KSIZE*DATA_WIDTH-1:0] rot_data;

  assign wr_ready    = (count_q != CW'(NUM_LINES));
  assign rd_ready    = (count_q >= CW'(KSIZE));
  assign lines_avail = count_q;
  assign state       = state_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign overflow_err = ovf_q;

  // A flush cycle accepts nothing so pointers and RAM writes stay coherent.
  assign wr_acc     = wr_valid & wr_ready & ~clear;
  assign rd_acc     = rd_en & rd_ready & ~clear;
  assign col_end    = (wr_col_q == ADDR_W'(DEPTH - 1));
  // A line closes on wr_last, or forcibly when its last column is filled.
  assign line_close = wr_acc & (wr_last | col_end);
  assign rel        = rd_release & (count_q != '0) & ~clear;

  // ---------------------------------------------------------------------
  // Line RAMs: one-hot write from wline, all lines read together
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    assign ram_we[gi] = wr_acc & (wline_q == LW'(gi));

    lb_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .we    (ram_we[gi]),
      .waddr (wr_col_q),
      .wdata (wr_data),
      .re    (rd_acc),
      .raddr (rd_addr),
      .rdata (ram_rdata[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Rotation mux: slot k takes line (rline + k) mod NUM_LINES, using the
  // rline captured with the read so a same-cycle release does not shift it.
  // One extra bit on the sum covers rline + k < 2*NUM_LINES.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < KSIZE; gi++) begin : g_slot
    logic [LW:0]   sum;
    logic [LW-1:0] idx;

    assign sum = {1'b0, rline_s1_q} + (LW+1)'(gi);
    assign idx = (sum >= (LW+1)'(NUM_LINES)) ? LW'(sum - (LW+1)'(NUM_LINES))
                                             : sum[LW-1:0];
    assign rot_data[gi*DATA_WIDTH +: DATA_WIDTH] = ram_rdata[idx];
  end

  // ---------------------------------------------------------------------
  // Write side, pointers and fill count
  // ---------------------------------------------------------------------
  always_comb begin
    wline_d    = wline_q;
    rline_d    = rline_q;
    wr_col_d   = wr_col_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rline_s1_d = rline_q;
    rd_s1_d    = rd_acc;
    rd_valid_d = rd_s1_q;
    rd_data_d  = rd_s1_q ? rot_data : '0;

    if (wr_acc) begin
      if (line_close) begin
        wr_col_d = '0;
        wline_d  = (wline_q == LW'(NUM_LINES - 1)) ? '0 : wline_q + LW'(1);
      end else begin
        wr_col_d = wr_col_q + ADDR_W'(1);
      end
      if (col_end && !wr_last) begin
        ovf_d = 1'b1;
      end
    end

    if (rel) begin
      rline_d = (rline_q == LW'(NUM_LINES - 1)) ? '0 : rline_q + LW'(1);
    end

    // Close and release together leave the count unchanged.
    case ({line_close, rel})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (clear) begin
      wline_d    = '0;
      rline_d    = '0;
      wr_col_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      rd_s1_d    = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Fill-level FSM, driven by the next count. The count moves by at most
  // one per cycle, so transitions are always to a neighbouring state.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      LB_FILL: begin
        if (count_d >= CW'(KSIZE)) state_d = LB_READY;
      end
      LB_READY: begin
        if (count_d == CW'(NUM_LINES))  state_d = LB_FULL;
        else if (count_d < CW'(KSIZE))  state_d = LB_FILL;
      end
      LB_FULL: begin
        if (count_d != CW'(NUM_LINES))  state_d = LB_READY;
      end
      default: state_d = LB_FILL;
    endcase
    if (clear) begin
      state_d = LB_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wline_q    <= '0;
      rline_q    <= '0;
      rline_s1_q <= '0;
      wr_col_q   <= '0;
      count_q    <= '0;
      state_q    <= LB_FILL;
      rd_s1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wline_q    <= wline_d;
      rline_q    <= rline_d;
      rline_s1_q <= rline_s1_d;
      wr_col_q   <= wr_col_d;
      count_q    <= count_d;
      state_q    <= state_d;
      rd_s1_q    <= rd_s1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_param_line_buffer_ring.sv
// Directed bench for param_line_buffer_ring (KSIZE=5, DEPTH=8).
// Column word of logical line n, column c is {32'(n), 32'(c)}; a read returns
// consecutive logical lines starting at the oldest unreleased one.
module tb_param_line_buffer_ring;

  localparam int DW = 64;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int KS = 5;
  localparam int NL = KS + 1;
  localparam int RW = KS * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          rd_en = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_release = 1'b0;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic [2:0]    lines_avail;
  logic [1:0]    state;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_line_buffer_ring #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .ADDR_W     (AW),
    .KSIZE      (KS),
    .NUM_LINES  (NL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .rd_en        (rd_en),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_release   (rd_release),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .lines_avail  (lines_avail),
    .state        (state),
    .overflow_err (overflow_err)
  );

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] pack(input int first, input int col);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < KS; k++) r[k*DW +: DW] = {32'(first + k), 32'(col)};
    return r;
  endfunction

  task automatic write_line(input int n, input int nwords, input bit last);
    for (int c = 0; c < nwords; c++) begin
      wr_valid = 1'b1;
      wr_data  = {32'(n), 32'(c)};
      wr_last  = last && (c == nwords - 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Single read: rd_valid must be low one cycle after acceptance and high
  // with the expected rows two cycles after.
  task automatic do_read(input string tag, input int col, input logic [RW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = AW'(col);
    tick();
    rd_en = 1'b0;
    chk({tag, "_lat1"}, rd_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    int oldest;

    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_lines", lines_avail, 3'd0);
    chk("rst_state", state, 2'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_ovf", overflow_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---------------- 1: fill five lines ----------------
    for (int n = 0; n < 4; n++) write_line(n, 4, 1'b1);
    chk("t1_rd_ready_4", rd_ready, 1'b0);
    chk("t1_lines_4", lines_avail, 3'd4);
    chk("t1_state_4", state, 2'd0);
    write_line(4, 4, 1'b1);
    chk("t1_rd_ready_5", rd_ready, 1'b1);
    chk("t1_lines_5", lines_avail, 3'd5);
    chk("t1_state_5", state, 2'd1);

    // ---------------- 2: reads ----------------
    do_read("t2_col2", 2, pack(0, 2));
    tick();
    chk("t2_valid_drop", rd_valid, 1'b0);
    chk("t2_data_zero", rd_data, '0);
    // back-to-back reads, one result per cycle
    rd_en = 1'b1; rd_addr = 3'd1;
    tick();
    rd_addr = 3'd3;
    tick();
    rd_en = 1'b0;
    chk("t2_pipe_v0", rd_valid, 1'b1);
    chk("t2_pipe_d0", rd_data, pack(0, 1));
    tick();
    chk("t2_pipe_v1", rd_valid, 1'b1);
    chk("t2_pipe_d1", rd_data, pack(0, 3));

    // ---------------- 3: full ring ----------------
    write_line(5, 4, 1'b1);
    chk("t3_state_full", state, 2'd2);
    chk("t3_wr_ready", wr_ready, 1'b0);
    chk("t3_lines6", lines_avail, 3'd6);
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = '1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("t3_blocked_lines", lines_avail, 3'd6);
    chk("t3_blocked_state", state, 2'd2);
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    chk("t3_rel_wr_ready", wr_ready, 1'b1);
    chk("t3_rel_lines", lines_avail, 3'd5);
    chk("t3_rel_state", state, 2'd1);
    do_read("t3_col0", 0, pack(1, 0));
    oldest = 1;

    // ---------------- 4: wrap the ring ----------------
    for (int n = 6; n < 14; n++) begin
      write_line(n, 4, 1'b1);
      chk($sformatf("t4_full_%0d", n), state, 2'd2);
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      oldest++;
      chk($sformatf("t4_lines_%0d", n), lines_avail, 3'd5);
      do_read($sformatf("t4_rd_%0d", n), n % 4, pack(oldest, n % 4));
    end

    // ---------------- 5: same-cycle close and release ----------------
    write_line(14, 3, 1'b0);
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = {32'd14, 32'd3};
    rd_release = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; rd_release = 1'b0;
    oldest++;
    chk("t5_lines", lines_avail, 3'd5);
    chk("t5_state", state, 2'd1);
    do_read("t5_col3", 3, pack(oldest, 3));
    // release together with a read: the read sees the pre-release lines
    rd_en = 1'b1; rd_addr = 3'd1; rd_release = 1'b1;
    tick();
    rd_en = 1'b0; rd_release = 1'b0;
    chk("t5_rr_lines", lines_avail, 3'd4);
    chk("t5_rr_state", state, 2'd0);
    chk("t5_rr_rd_ready", rd_ready, 1'b0);
    tick();
    chk("t5_rr_valid", rd_valid, 1'b1);
    chk("t5_rr_data", rd_data, pack(oldest, 1));
    // read request while not ready is dropped
    rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    rd_en = 1'b0;
    tick();
    chk("t5_drop_v0", rd_valid, 1'b0);
    tick();
    chk("t5_drop_v1", rd_valid, 1'b0);
    // drain, then one extra release at zero count
    rd_release = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rd_release = 1'b0;
    chk("t5_rel0_lines", lines_avail, 3'd0);
    chk("t5_rel0_state", state, 2'd0);
    chk("t5_rel0_wr_ready", wr_ready, 1'b1);
    write_line(15, 4, 1'b1);
    chk("t5_after_lines", lines_avail, 3'd1);

    // ---------------- 6: overflow, clear, async reset ----------------
    write_line(16, 7, 1'b0);
    chk("t6_ovf_pre", overflow_err, 1'b0);
    chk("t6_lines_pre", lines_avail, 3'd1);
    write_line(16, 1, 1'b0);
    chk("t6_ovf", overflow_err, 1'b1);
    chk("t6_lines_auto", lines_avail, 3'd2);
    for (int n = 17; n < 20; n++) write_line(n, 4, 1'b1);
    chk("t6_lines5", lines_avail, 3'd5);
    rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    rd_en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_valid", rd_valid, 1'b0);
    chk("t6_clr_data", rd_data, '0);
    chk("t6_clr_ovf", overflow_err, 1'b0);
    chk("t6_clr_lines", lines_avail, 3'd0);
    chk("t6_clr_state", state, 2'd0);
    tick();
    chk("t6_clr_valid2", rd_valid, 1'b0);
    write_line(20, 4, 1'b1);
    write_line(21, 2, 1'b0);
    chk("t6_pre_rst_lines", lines_avail, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_lines", lines_avail, 3'd0);
    chk("t6_arst_wr_ready", wr_ready, 1'b1);
    chk("t6_arst_state", state, 2'd0);
    chk("t6_arst_ovf", overflow_err, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    for (int n = 30; n < 35; n++) write_line(n, 4, 1'b1);
    chk("t6_post_lines", lines_avail, 3'd5);
    do_read("t6_post_col3", 3, pack(30, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
